int_sequencer: RTL
==================

Name: int_sequencer

Overview:
- Interrupt controller for the PIC16F core. Owns the INTCON register and latches interrupt flags from timer0, the INT pin, PORTB-change and peripheral sources.
- At a legal instruction boundary, when an enabled interrupt is pending, it takes over sequencing for two instruction cycles (8 clocks): push the return PC, jump to the vector, then a forced-NOP refetch.
- Sits beside instruction_decoder. Its control outputs are ORed with, or gate, the decoder's outputs at top level.

Parameters:
- PC_WIDTH, 13, width of pc_vector.
- INT_VECTOR, 13'h004, interrupt vector address.
- SYNC_STAGES, 2, synchronizer depth for int_pin.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- q_count  in  2  decoder Q-phase (0..3)
- instr_boundary  in  1  decoder strobe at q_count==3 of any instruction that ends with a normal fetch. Not asserted at goto's q3.
- retfie  in  1  pulse at q3 of RETFIE; sets GIE
- intcon_wr_en  in  1  software write strobe
- intcon_wr_data  in  8  software write data
- intcon_rd_data  out  8  current INTCON (registered)
- intedg  in  1  OPTION_REG INTEDG: 1 = rising, 0 = falling
- int_pin  in  1  asynchronous external interrupt pin
- t0_ovf  in  1  1-clock timer0 overflow pulse
- rb_change  in  1  1-clock PORTB change pulse
- periph_irq  in  1  level, ORed peripheral requests
- irq_take  out  1  combinational; top level gates the decoder's instr_rd_en/pc_incr_en with ~irq_take
- int_active  out  1  high during INT_C1/INT_C2; decoder outputs suppressed
- stack_push  out  1  1-clock push of current PC
- pc_vec_load  out  1  1-clock load of pc_vector into PC
- pc_vector  out  PC_WIDTH  constant INT_VECTOR
- int_flush  out  1  flush instruction register
- int_instr_rd_en  out  1  forced fetch
- int_pc_incr_en  out  1  forced PC increment

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - INTCON resets to 8'h00 and state to IDLE.
  - All pulse outputs are 0 and the sync chain is 0.
  - Pin edges are ignored for SYNC_STAGES+1 clocks after rst deasserts.
  - rst mid-sequence aborts to IDLE with no further pulses.
- INTCON bits: 7 GIE, 6 PEIE, 5 T0IE, 4 INTE, 3 RBIE, 2 T0IF, 1 INTF, 0 RBIF.
- Flag setting:
  - t0_ovf sets T0IF.
  - A synced pin edge of the intedg polarity sets INTF.
  - rb_change sets RBIF.
  - Flags set regardless of enables.
- Priority on the same edge, highest first:
  - GIE: irq take > retfie > software write.
  - Flags: hardware set > software write.
  - The software write otherwise loads all 8 bits.
- pending = GIE & ((T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (PEIE&periph_irq)).
- irq_take = (state==IDLE) & (q_count==3) & instr_boundary & pending.
- FSM states: IDLE, INT_C1, INT_C2.
- IDLE: on irq_take, on that edge go to INT_C1 and clear GIE.
- INT_C1 (4 clocks):
  - int_active=1.
  - q0: stack_push=1. PC still holds the return address, because the decoder increment was gated.
  - q3: pc_vec_load=1 and int_flush=1, then go to INT_C2.
- INT_C2 (4 clocks):
  - int_active=1.
  - q3: int_instr_rd_en=1 and int_pc_incr_en=1, then go to IDLE.
- Once the decoder resumes, it executes the instruction fetched from INT_VECTOR.
- Interrupt latency from take to resume is exactly 8 clocks.
- New flags raised during INT_C1/C2 latch normally. They cannot re-trigger until GIE is set again.
- retfie while in IDLE sets GIE. If a flag is still pending at the next boundary, a new take occurs there (back-to-back).
- Flags are never cleared by hardware. Software clears them.
- q_count outside the expected phase is not checked. The FSM advances on q_count==3 only.

Decomposition:
- Shared header int_defs.vh holds:
  - INTCON bit indices
  - FSM state encodings
  - default INT_VECTOR
- Sub-module int_pin_sync: SYNC_STAGES flip-flop synchronizer, post-reset edge blanking counter, and polarity-selected edge detector. Output is a 1-clock edge pulse.

Test Plan:
- Write INTCON=8'hA0 (GIE, T0IE), pulse t0_ovf at a mid-instruction q1 → T0IF=1 and intcon_rd_data=8'hA4.
  - At the next q3 with instr_boundary: irq_take=1, then GIE=0.
  - Next q0: stack_push. Next q3: pc_vec_load with pc_vector=13'h004.
  - 4 clocks later: int_instr_rd_en and int_pc_incr_en pulse, then IDLE.
- INTE=1, GIE=1, intedg=1; drive int_pin 0→1 → INTF sets exactly SYNC_STAGES+1 clocks later.
  - Same with intedg=0 and a 0→1 edge → no INTF.
- Flags set but GIE=0, instr_boundary every q3 for 10 instructions → irq_take never asserts.
  - Then pulse retfie → take at the next boundary.
- Same edge: software write 8'h00 and t0_ovf → T0IF=1 and GIE=0.
  - Same edge: retfie and a write with GIE=0 → GIE=1.
- irq pending but the boundary is goto's q3 (instr_boundary=0) → no take. Take occurs at the following forced-NOP's q3.
- Assert rst at q2 of INT_C1 → no pc_vec_load, INTCON=8'h00, state IDLE.
  - int_pin held high through reset → no INTF after release.

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: INTCON bit positions,
// FSM state encodings, the default vector and the pending-interrupt rule.
package int_sequencer_pkg;

  localparam int GIE_B  = 7;
  localparam int PEIE_B = 6;
  localparam int T0IE_B = 5;
  localparam int INTE_B = 4;
  localparam int RBIE_B = 3;
  localparam int T0IF_B = 2;
  localparam int INTF_B = 1;
  localparam int RBIF_B = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INT_C1 = 2'd1;
  localparam logic [1:0] ST_INT_C2 = 2'd2;

  localparam logic [1:0]  Q_FIRST        = 2'd0;
  localparam logic [1:0]  Q_LAST         = 2'd3;
  localparam logic [12:0] INT_VECTOR_DEF = 13'h004;

  // An interrupt is pending when GIE is set and any source has both its
  // enable and its flag (the peripheral source is a live level).
  function automatic logic irq_pending(input logic [7:0] intcon, input logic periph);
    return intcon[GIE_B] & ((intcon[T0IE_B] & intcon[T0IF_B]) |
                            (intcon[INTE_B] & intcon[INTF_B]) |
                            (intcon[RBIE_B] & intcon[RBIF_B]) |
                            (intcon[PEIE_B] & periph));
  endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Bundle of the decoder-side, INTCON bus and interrupt-source signals of
// the interrupt sequencer. The sequencer is the slave; the core/decoder
// side (or a bench) is the master.
interface int_sequencer_if #(parameter int PC_WIDTH = 13);
  logic [1:0]          q_count;
  logic                instr_boundary;
  logic                retfie;
  logic                intcon_wr_en;
  logic [7:0]          intcon_wr_data;
  logic [7:0]          intcon_rd_data;
  logic                intedg;
  logic                int_pin;
  logic                t0_ovf;
  logic                rb_change;
  logic                periph_irq;
  logic                irq_take;
  logic                int_active;
  logic                stack_push;
  logic                pc_vec_load;
  logic [PC_WIDTH-1:0] pc_vector;
  logic                int_flush;
  logic                int_instr_rd_en;
  logic                int_pc_incr_en;

  modport master (
    output q_count, instr_boundary, retfie, intcon_wr_en, intcon_wr_data,
           intedg, int_pin, t0_ovf, rb_change, periph_irq,
    input  intcon_rd_data, irq_take, int_active, stack_push, pc_vec_load,
           pc_vector, int_flush, int_instr_rd_en, int_pc_incr_en
  );

  modport slave (
    input  q_count, instr_boundary, retfie, intcon_wr_en, intcon_wr_data,
           intedg, int_pin, t0_ovf, rb_change, periph_irq,
    output intcon_rd_data, irq_take, int_active, stack_push, pc_vec_load,
           pc_vector, int_flush, int_instr_rd_en, int_pc_incr_en
  );
endinterface

// File: rtl/int_sequencer_pin_sync.sv
// External interrupt pin conditioning: multi-flop synchronizer, edge
// blanking right after reset, and an edge detector whose polarity follows
// INTEDG. Produces a single-clock pulse per qualifying edge.
module int_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic int_pin,
  input  logic intedg,
  output logic edge_pulse
);

  localparam int BLANK = SYNC_STAGES + 1;
  localparam int CNT_W = $clog2(BLANK + 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   synced_prev_p;
  logic [CNT_W-1:0]       blank_cnt;
  logic                   synced;
  logic                   rise;
  logic                   fall;

  // Synchronizer chain, previous-sample register and post-reset blanking count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p        <= '0;
      synced_prev_p <= 1'b0;
      blank_cnt     <= CNT_W'(BLANK);
    end else begin
      sync_p[0] <= int_pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
      synced_prev_p <= sync_p[SYNC_STAGES-1];
      if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

  assign synced     = sync_p[SYNC_STAGES-1];
  assign rise       = synced & ~synced_prev_p;
  assign fall       = ~synced & synced_prev_p;
  // Edges seen while the chain is still refilling after reset are not real
  assign edge_pulse = (blank_cnt == '0) & (intedg ? rise : fall);

endmodule

// File: rtl/int_sequencer.sv
// PIC16F interrupt sequencer: owns INTCON, latches interrupt flags, and at
// an instruction boundary with an enabled pending interrupt takes over
// sequencing for two instruction cycles (push PC, vector, forced refetch).
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH    = 13,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR  = PC_WIDTH'(INT_VECTOR_DEF),
  parameter int                  SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  int_sequencer_if.slave bus
);

  logic [7:0] intcon;
  logic [7:0] intcon_nxt;
  logic [1:0] state;
  logic       q_last;
  logic       q_first;
  logic       pending;
  logic       take;
  logic       in_c1;
  logic       in_c2;
  logic       pin_edge;

  int_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk        (clk),
    .rst        (rst),
    .int_pin    (bus.int_pin),
    .intedg     (bus.intedg),
    .edge_pulse (pin_edge)
  );

  assign q_last  = (bus.q_count == Q_LAST);
  assign q_first = (bus.q_count == Q_FIRST);
  assign pending = irq_pending(intcon, bus.periph_irq);

  // Outputs are gated by rst so an aborted sequence emits nothing further
  assign take  = ~rst & (state == ST_IDLE) & q_last & bus.instr_boundary & pending;
  assign in_c1 = ~rst & (state == ST_INT_C1);
  assign in_c2 = ~rst & (state == ST_INT_C2);

  assign bus.irq_take        = take;
  assign bus.int_active      = in_c1 | in_c2;
  assign bus.stack_push      = in_c1 & q_first;
  assign bus.pc_vec_load     = in_c1 & q_last;
  assign bus.int_flush       = in_c1 & q_last;
  assign bus.int_instr_rd_en = in_c2 & q_last;
  assign bus.int_pc_incr_en  = in_c2 & q_last;
  assign bus.pc_vector       = INT_VECTOR;
  assign bus.intcon_rd_data  = intcon;

  // Next INTCON: software write loads all bits, GIE is overridden by a take
  // (clear) or RETFIE (set), and hardware flag sets win over the write.
  always_comb begin
    intcon_nxt = bus.intcon_wr_en ? bus.intcon_wr_data : intcon;
    if (take) begin
      intcon_nxt[GIE_B] = 1'b0;
    end else if (bus.retfie) begin
      intcon_nxt[GIE_B] = 1'b1;
    end
    if (bus.t0_ovf) begin
      intcon_nxt[T0IF_B] = 1'b1;
    end
    if (pin_edge) begin
      intcon_nxt[INTF_B] = 1'b1;
    end
    if (bus.rb_change) begin
      intcon_nxt[RBIF_B] = 1'b1;
    end
  end

  // INTCON register
  always_ff @(posedge clk) begin
    if (rst) begin
      intcon <= 8'h00;
    end else begin
      intcon <= intcon_nxt;
    end
  end

  // Sequencing FSM; every transition happens at the end of a q3 clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (take)   state <= ST_INT_C1;
        ST_INT_C1: if (q_last) state <= ST_INT_C2;
        ST_INT_C2: if (q_last) state <= ST_IDLE;
        default:               state <= ST_IDLE;
      endcase
    end
  end

endmodule
